// File: rtl/lms_adapt_engine_if.sv
// Bundles the sample, control, coefficient and status signals of the LMS adaptation engine.
interface lms_adapt_engine_if #(
  parameter int NBX   = 8,
  parameter int NBY   = 8,
  parameter int NW    = 9,
  parameter int NBW   = 7,
  parameter int NBMU  = 8,
  parameter int NBCNT = 16
);
  logic                    i_enable;
  logic                    d;
  logic signed [NBY-1:0]   y;
  logic signed [NBX-1:0]   x;
  logic [1:0]              i_mode;
  logic                    i_freeze;
  logic                    i_leak_en;
  logic [NBMU-1:0]         i_mu_acq;
  logic [NBMU-1:0]         i_mu_trk;
  logic [NBCNT-1:0]        i_acq_len;
  logic                    debug_load;
  logic [NW*NBW-1:0]       i_coeffs;
  logic [NW*NBW-1:0]       coeff;
  logic signed [NBY:0]     e_out;
  logic [1:0]              o_state;
  logic                    o_sat;
  logic                    o_upd;

  modport master (
    output i_enable, d, y, x, i_mode, i_freeze, i_leak_en, i_mu_acq, i_mu_trk,
           i_acq_len, debug_load, i_coeffs,
    input  coeff, e_out, o_state, o_sat, o_upd
  );

  modport slave (
    input  i_enable, d, y, x, i_mode, i_freeze, i_leak_en, i_mu_acq, i_mu_trk,
           i_acq_len, debug_load, i_coeffs,
    output coeff, e_out, o_state, o_sat, o_upd
  );
endinterface

// File: rtl/lms_adapt_engine.sv
// NW-tap LMS coefficient updater: slicer error, tap line, three adaptation laws,
// two-phase step size (ACQ/TRK/FRZ), leakage, sticky saturation and update strobe.
module lms_adapt_engine #(
  parameter int NBX     = 8,
  parameter int NBFX    = 5,
  parameter int NBY     = 8,
  parameter int NBFY    = 5,
  parameter int NW      = 9,
  parameter int NBW     = 7,
  parameter int NBFW    = 5,
  parameter int NBMU    = 8,
  parameter int UPD_DIV = 2,
  parameter int LEAK_SH = 10,
  parameter int NBCNT   = 16
) (
  input logic               clkA,
  input logic               reset,
  lms_adapt_engine_if.slave bus
);
  localparam int NBE    = NBY + 1;
  localparam int NBACC  = NBX + NBMU + NBE;
  localparam int NBFACC = NBFX + NBMU - 1 + NBFY;
  localparam int NBS    = NBACC + 1;
  localparam int EXP_SH = NBFACC - NBFW;
  localparam int NBEXP  = NBACC - EXP_SH;
  localparam int NBDIV  = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;

  localparam logic signed [NBE-1:0]   E_POS   = NBE'(2**NBFY);
  localparam logic signed [NBE-1:0]   E_NEG   = NBE'(-(2**NBFY));
  localparam logic signed [NBX-1:0]   X_POS   = NBX'(2**NBFX);
  localparam logic signed [NBX-1:0]   X_NEG   = NBX'(-(2**NBFX));
  localparam logic signed [NBACC-1:0] ACC_ONE = NBACC'(2**NBFACC);
  localparam logic signed [NBACC-1:0] ACC_MAX = {1'b0, {(NBACC-1){1'b1}}};
  localparam logic signed [NBACC-1:0] ACC_MIN = {1'b1, {(NBACC-1){1'b0}}};
  localparam logic signed [NBEXP-1:0] EXP_MAX = NBEXP'(2**(NBW-1) - 1);
  localparam logic signed [NBEXP-1:0] EXP_MIN = NBEXP'(-(2**(NBW-1)));

  typedef enum logic [1:0] {ACQ = 2'd0, TRK = 2'd1, FRZ = 2'd2} state_t;

  state_t                  state_reg, state_next;
  logic                    acq_done_reg;
  logic [NBCNT-1:0]        acq_cnt_reg;
  logic [NBDIV-1:0]        div_reg;
  logic                    sat_reg, upd_reg;
  logic signed [NBX-1:0]   x_reg [NW];
  logic signed [NBACC-1:0] w_reg [NW];
  logic signed [NBACC-1:0] w_upd [NW];
  logic signed [NBACC-1:0] w_load [NW];
  logic [NW-1:0]           clip;
  logic [NW*NBW-1:0]       coeff_pk;

  logic                    active, acq_last, div_last, do_update;
  logic                    sign_err, sign_x;
  logic [NBMU-1:0]         mu;
  logic signed [NBMU:0]    mu_s;
  logic signed [NBE-1:0]   d_e, e, e_op;

  assign d_e = bus.d ? E_POS : E_NEG;
  assign e   = d_e - {bus.y[NBY-1], bus.y};

  assign sign_err = (bus.i_mode == 2'd1) || (bus.i_mode == 2'd2);
  assign sign_x   = (bus.i_mode == 2'd2);
  assign e_op     = sign_err ? (e[NBE-1] ? E_NEG : E_POS) : e;
  assign mu_s     = {1'b0, mu};

  assign acq_last  = (bus.i_acq_len == '0) || (acq_cnt_reg == bus.i_acq_len - NBCNT'(1));
  assign div_last  = (div_reg == NBDIV'(UPD_DIV - 1));
  assign do_update = bus.i_enable && active && div_last && !bus.debug_load;

  always_ff @(posedge clkA or posedge reset) begin
    if (reset) state_reg <= ACQ;
    else       state_reg <= state_next;
  end

  // Freeze dominates; leaving FRZ returns to whichever phase was interrupted.
  always_comb begin
    state_next = state_reg;
    if (bus.i_freeze) begin
      state_next = FRZ;
    end else begin
      case (state_reg)
        ACQ:     if (bus.i_enable && acq_last) state_next = TRK;
        TRK:     state_next = TRK;
        FRZ:     state_next = acq_done_reg ? TRK : ACQ;
        default: state_next = ACQ;
      endcase
    end
  end

  always_comb begin
    active = (state_reg != FRZ) && !bus.i_freeze;
    mu     = (state_reg == ACQ) ? bus.i_mu_acq : bus.i_mu_trk;
  end

  always_ff @(posedge clkA or posedge reset) begin
    if (reset) begin
      acq_cnt_reg  <= '0;
      div_reg      <= '0;
      acq_done_reg <= 1'b0;
    end else begin
      if (bus.i_enable && active) begin
        div_reg <= div_last ? '0 : div_reg + NBDIV'(1);
        if (state_reg == ACQ) acq_cnt_reg <= acq_cnt_reg + NBCNT'(1);
      end
      if (state_next == TRK) acq_done_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NW; gi++) begin : g_tap
    logic signed [NBX-1:0]   x_op;
    logic signed [NBS-1:0]   w_ext, w_shr, term, leak, sum;
    logic signed [NBEXP-1:0] w_top;
    logic signed [NBW-1:0]   load_fld;

    assign x_op  = sign_x ? (x_reg[gi][NBX-1] ? X_NEG : X_POS) : x_reg[gi];
    assign term  = NBS'(mu_s) * NBS'(e_op) * NBS'(x_op);
    assign w_ext = NBS'(w_reg[gi]);
    assign w_shr = w_ext >>> LEAK_SH;
    assign leak  = bus.i_leak_en ? w_shr : '0;
    assign sum   = w_ext + term - leak;

    assign clip[gi]  = sum[NBS-1] != sum[NBS-2];
    assign w_upd[gi] = clip[gi] ? (sum[NBS-1] ? ACC_MIN : ACC_MAX) : sum[NBACC-1:0];

    assign load_fld   = bus.i_coeffs[NBW*(gi+1)-1 -: NBW];
    assign w_load[gi] = NBACC'(load_fld) <<< EXP_SH;

    // Drop fractional bits below NBFW, then clamp to the exported range.
    assign w_top = w_reg[gi][NBACC-1:EXP_SH];
    assign coeff_pk[NBW*(gi+1)-1 -: NBW] =
        (w_top > EXP_MAX) ? EXP_MAX[NBW-1:0] :
        (w_top < EXP_MIN) ? EXP_MIN[NBW-1:0] : w_top[NBW-1:0];
  end

  always_ff @(posedge clkA or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NW; k++) begin
        x_reg[k] <= '0;
        w_reg[k] <= (k == NW/2) ? ACC_ONE : '0;
      end
      sat_reg <= 1'b0;
      upd_reg <= 1'b0;
    end else begin
      if (bus.i_enable) begin
        x_reg[0] <= bus.x;
        for (int k = 1; k < NW; k++) x_reg[k] <= x_reg[k-1];
      end
      upd_reg <= do_update;
      if (bus.debug_load) begin
        for (int k = 0; k < NW; k++) w_reg[k] <= w_load[k];
      end else if (do_update) begin
        for (int k = 0; k < NW; k++) w_reg[k] <= w_upd[k];
        if (|clip) sat_reg <= 1'b1;
      end
    end
  end

  assign bus.coeff   = coeff_pk;
  assign bus.e_out   = e;
  assign bus.o_state = state_reg;
  assign bus.o_sat   = sat_reg;
  assign bus.o_upd   = upd_reg;
endmodule

// File: tb/tb_lms_adapt_engine.sv
// Directed bench for lms_adapt_engine: stimulus pushes hand-computed coefficient sets,
// a monitor pops and compares one entry per o_upd pulse.
module tb_lms_adapt_engine;
  localparam int NW = 9;
  localparam int NBW = 7;
  localparam int CW = NW * NBW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lms_adapt_engine_if bus_if ();
  lms_adapt_engine dut (.clkA(clk), .reset(rst), .bus(bus_if));

  typedef struct {
    logic [CW-1:0] exp;
    logic [CW-1:0] mask;
    logic [1:0]    st;
    bit            sat_chk;
    logic          sat;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int n_upd = 0;

  logic [CW-1:0] rst_c, all_m, e_val, pat;

  function automatic logic [CW-1:0] f(input int k, input logic [6:0] v);
    logic [CW-1:0] r;
    r = '0;
    r[k*NBW +: NBW] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [CW-1:0] ev, input logic [CW-1:0] m, input logic [1:0] st,
                      input bit sc, input logic s);
    exp_t t;
    t.exp = ev; t.mask = m; t.st = st; t.sat_chk = sc; t.sat = s;
    sb_q.push_back(t);
  endtask

  always @(negedge clk) begin
    exp_t t;
    if (!rst && bus_if.o_upd) begin
      n_upd++;
      $display("upd %0d coeff=%h state=%0d sat=%b", n_upd, bus_if.coeff, bus_if.o_state, bus_if.o_sat);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL upd_spurious got o_upd=1 expected no update");
      end else begin
        t = sb_q.pop_front();
        chk("upd_coeff", bus_if.coeff & t.mask, t.exp & t.mask);
        chk("upd_state", bus_if.o_state, t.st);
        if (t.sat_chk) chk("upd_sat", bus_if.o_sat, t.sat);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic en(input logic [7:0] xv);
    bus_if.x = xv;
    bus_if.i_enable = 1'b1;
    @(posedge clk);
    #1;
    bus_if.i_enable = 1'b0;
  endtask

  task automatic set_defaults();
    bus_if.i_enable = 0; bus_if.d = 1; bus_if.y = '0; bus_if.x = '0;
    bus_if.i_mode = 2'd0; bus_if.i_freeze = 0; bus_if.i_leak_en = 0;
    bus_if.i_mu_acq = '0; bus_if.i_mu_trk = '0; bus_if.i_acq_len = 16'hFFFF;
    bus_if.debug_load = 0; bus_if.i_coeffs = '0;
  endtask

  task automatic do_reset();
    idle(2);
    chk("sb_pending", sb_q.size(), 0);
    sb_q.delete();
    rst = 1'b1;
    set_defaults();
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    rst_c = f(4, 7'h20);
    all_m = '1;
    set_defaults();
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("rst_coeff", bus_if.coeff, rst_c);
    chk("rst_state", bus_if.o_state, 2'd0);
    chk("rst_sat", bus_if.o_sat, 1'b0);
    chk("rst_upd", bus_if.o_upd, 1'b0);

    // Mode 0, mu = 0.125, e = +1, x = +1: first update lands on tap 0.
    bus_if.i_mu_acq = 8'h10;
    #1 chk("e_out_pos", {bus_if.e_out}, 9'h020);
    push(rst_c | f(0, 7'h04), all_m, 2'd0, 1, 1'b0);
    en(8'h20); en(8'h20);
    push(rst_c | f(0, 7'h04) | f(1, 7'h04) | f(2, 7'h04), all_m, 2'd0, 1, 1'b0);
    en(8'h00); en(8'h00);
    chk("m0_coeff", bus_if.coeff, rst_c | f(0, 7'h04) | f(1, 7'h04) | f(2, 7'h04));

    // Mode 1: e = -0.5 replaced by -1, x = +0.5 -> tap 0 moves by -1/16.
    do_reset();
    bus_if.i_mode = 2'd1; bus_if.i_mu_acq = 8'h10; bus_if.y = 8'h30;
    #1 chk("e_out_neg", {bus_if.e_out}, 9'h1F0);
    push(rst_c | f(0, 7'h7E), all_m, 2'd0, 1, 1'b0);
    en(8'h10); en(8'h10);

    // Mode 3 behaves as LMS: d = -1, y = 1.5 -> e = -2.5, term = -5/32.
    do_reset();
    bus_if.i_mode = 2'd3; bus_if.i_mu_acq = 8'h10; bus_if.d = 0; bus_if.y = 8'h30;
    #1 chk("e_out_d0", {bus_if.e_out}, 9'h1B0);
    push(rst_c | f(0, 7'h7B), all_m, 2'd0, 1, 1'b0);
    en(8'h10); en(8'h10);

    // Mode 2: fill the line (mu = 0), then one sign-sign update with x_r[0] = -0.25.
    do_reset();
    bus_if.i_mode = 2'd2; bus_if.y = 8'h10;
    #1 chk("e_out_half", {bus_if.e_out}, 9'h010);
    e_val = f(0, 7'h7C);
    for (int k = 1; k < NW; k++) e_val = e_val | f(k, (k == 4) ? 7'h24 : 7'h04);
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 0 && i < 10) push(rst_c, all_m, 2'd0, 1, 1'b0);
      if (i == 10) begin
        bus_if.i_mu_acq = 8'h10;
        push(e_val, all_m, 2'd0, 1, 1'b0);
      end
      en((i == 9) ? 8'hF8 : 8'h20);
    end

    // Saturation: mu ~ 1, e = +1, x_r[0] = +1 at every update.
    do_reset();
    bus_if.i_mu_acq = 8'h7F;
    for (int u = 1; u <= 140; u++) begin
      push(f(0, (u == 1) ? 7'h1F : 7'h3F), f(0, 7'h7F), 2'd0, (u <= 2), 1'b0);
      en(8'h20); en(8'h00);
    end
    bus_if.i_mu_acq = 8'h00;
    idle(3);
    chk("sat_set", bus_if.o_sat, 1'b1);
    chk("sat_field0", {bus_if.coeff[6:0]}, 7'h3F);
    bus_if.d = 0; bus_if.y = 8'h55;
    idle(6);
    chk("sat_sticky", bus_if.o_sat, 1'b1);

    // Leakage alone pulls the centre tap just below 1.0.
    do_reset();
    bus_if.i_leak_en = 1;
    push(f(4, 7'h1F), all_m, 2'd0, 1, 1'b0);
    en(8'h00); en(8'h00);

    // Acquisition length 4, then tracking step 1/32.
    do_reset();
    bus_if.i_acq_len = 16'd4; bus_if.i_mu_acq = 8'h10; bus_if.i_mu_trk = 8'h04;
    push(rst_c | f(0, 7'h04), all_m, 2'd0, 1, 1'b0);
    en(8'h20); en(8'h20);
    push(rst_c | f(0, 7'h08) | f(1, 7'h04) | f(2, 7'h04), all_m, 2'd1, 1, 1'b0);
    en(8'h20);
    chk("acq_state3", bus_if.o_state, 2'd0);
    en(8'h20);
    chk("acq_to_trk", bus_if.o_state, 2'd1);
    push(f(0, 7'h09) | f(1, 7'h05) | f(2, 7'h05) | f(3, 7'h01) | f(4, 7'h21), all_m, 2'd1, 1, 1'b0);
    en(8'h20); en(8'h20);

    // Freeze mid-ACQ: coefficients hold, the line keeps shifting, ACQ resumes.
    do_reset();
    bus_if.i_acq_len = 16'd4; bus_if.i_mu_acq = 8'h10;
    push(rst_c | f(0, 7'h04), all_m, 2'd0, 1, 1'b0);
    en(8'h20); en(8'h20);
    idle(1);
    bus_if.i_freeze = 1;
    idle(1);
    chk("frz_state", bus_if.o_state, 2'd2);
    en(8'h10); en(8'h10); en(8'h10);
    chk("frz_hold", bus_if.coeff, rst_c | f(0, 7'h04));
    bus_if.i_freeze = 0;
    idle(1);
    chk("frz_to_acq", bus_if.o_state, 2'd0);
    push(f(0, 7'h08) | f(1, 7'h02) | f(2, 7'h02) | f(3, 7'h02) | f(4, 7'h24) | f(5, 7'h04),
         all_m, 2'd1, 1, 1'b0);
    en(8'h20); en(8'h20);
    chk("frz_acq_done", bus_if.o_state, 2'd1);
    bus_if.i_freeze = 1;
    idle(1);
    chk("frz_trk", bus_if.o_state, 2'd2);
    bus_if.i_freeze = 0;
    idle(1);
    chk("frz_to_trk", bus_if.o_state, 2'd1);

    // Debug load on an update cycle wins and suppresses o_upd.
    do_reset();
    bus_if.i_mu_acq = 8'h10;
    en(8'h20);
    pat = '0;
    for (int k = 0; k < NW; k++) pat = pat | f(k, 7'h01);
    bus_if.i_coeffs = pat;
    bus_if.debug_load = 1;
    en(8'h20);
    bus_if.debug_load = 0;
    idle(2);
    chk("load_coeff", bus_if.coeff, pat);
    chk("load_state", bus_if.o_state, 2'd0);
    pat = f(0, 7'h40) | f(1, 7'h3F) | f(2, 7'h7F) | f(3, 7'h01) | f(4, 7'h20) |
          f(5, 7'h55) | f(6, 7'h2A) | f(7, 7'h00) | f(8, 7'h7E);
    bus_if.i_coeffs = pat;
    bus_if.debug_load = 1;
    idle(1);
    bus_if.debug_load = 0;
    idle(1);
    chk("load_signed", bus_if.coeff, pat);

    idle(3);
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
